// File: rtl/uart_txq.sv
// UART transmit channel with an integrated FIFO, runtime frame format (5-9 data bits,
// parity, 1/2 stop bits), CTS flow control and a sticky overflow flag.
module uart_txq #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WADDR = 5,
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] ckdiv,
    input  logic [3:0]       dbits,
    input  logic [1:0]       parity,
    input  logic             stop2b,
    input  logic             cts_en,
    input  logic             cts_n,
    input  logic             wr,
    input  logic [8:0]       wdata,
    output logic             full,
    output logic             empty,
    output logic [WADDR:0]   level,
    output logic             ovf,
    output logic             txbusy,
    output logic             done,
    output logic             txd
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam logic [WADDR:0] FULL_LVL = DEPTH[WADDR:0];

    state_t           state;
    logic [8:0]       mem [DEPTH];
    logic [WADDR-1:0] wptr, rptr;
    logic [WADDR:0]   level_q;
    logic             cts_m, cts_s;
    logic [DIV_W-1:0] div_q, cnt;
    logic [3:0]       nbits_q, bitn;
    logic             par_en_q, par_bit_q, stop2_q, sbit;
    logic [8:0]       shreg;
    logic             txd_q, busy_q;

    logic             start_ok, bit_end, last_stop, frame_end, pop, push;
    logic [3:0]       nbits_c;
    logic [8:0]       mask_c, data_c;
    logic             par_c;

    assign level = level_q;
    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign txd    = txd_q;
    assign txbusy = busy_q;

    assign start_ok  = !cts_en || !cts_s;
    assign bit_end   = (cnt == div_q);
    assign last_stop = !stop2_q || sbit;
    assign frame_end = (state == STOP) && bit_end && last_stop;
    // A pop either starts from IDLE or chains straight out of the last stop bit.
    assign pop  = !clr && !empty && start_ok && ((state == IDLE) || frame_end);
    assign push = !clr && wr && !full;
    assign done = frame_end;

    always_comb begin
        nbits_c = dbits;
        if (dbits < 4'd5)
            nbits_c = 4'd5;
        else if (dbits > 4'd9)
            nbits_c = 4'd9;
        case (nbits_c)
            4'd5:    mask_c = 9'h01F;
            4'd6:    mask_c = 9'h03F;
            4'd7:    mask_c = 9'h07F;
            4'd8:    mask_c = 9'h0FF;
            default: mask_c = 9'h1FF;
        endcase
        data_c = mem[rptr] & mask_c;
        case (parity)
            2'b01:   par_c = ~^data_c;
            2'b10:   par_c = ^data_c;
            default: par_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            ovf     <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (wr && full)
                ovf <= 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_m <= 1'b1;
            cts_s <= 1'b1;
        end else begin
            cts_m <= cts_n;
            cts_s <= cts_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            cnt       <= '0;
            div_q     <= '0;
            nbits_q   <= 4'd5;
            bitn      <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            sbit      <= 1'b0;
            shreg     <= '0;
        end else if (clr) begin
            state  <= IDLE;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
        end else if (pop) begin
            state     <= START;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
            cnt       <= '0;
            div_q     <= ckdiv;
            nbits_q   <= nbits_c;
            par_en_q  <= (parity != 2'b00);
            par_bit_q <= par_c;
            stop2_q   <= stop2b;
            shreg     <= data_c;
        end else begin
            if (state != IDLE)
                cnt <= bit_end ? '0 : cnt + 1'b1;
            unique case (state)
                IDLE: ;
                START:
                    if (bit_end) begin
                        state <= DATA;
                        txd_q <= shreg[0];
                        shreg <= shreg >> 1;
                        bitn  <= 4'd1;
                    end
                DATA:
                    if (bit_end) begin
                        if (bitn == nbits_q) begin
                            if (par_en_q) begin
                                state <= PAR;
                                txd_q <= par_bit_q;
                            end else begin
                                state <= STOP;
                                txd_q <= 1'b1;
                                sbit  <= 1'b0;
                            end
                        end else begin
                            txd_q <= shreg[0];
                            shreg <= shreg >> 1;
                            bitn  <= bitn + 1'b1;
                        end
                    end
                PAR:
                    if (bit_end) begin
                        state <= STOP;
                        txd_q <= 1'b1;
                        sbit  <= 1'b0;
                    end
                STOP:
                    if (bit_end) begin
                        if (!last_stop) begin
                            sbit <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txq.sv
// Directed self-checking bench for uart_txq: frame shapes, parity, clamping, chaining,
// flow control, overflow, reset and clear.
module tb_uart_txq;

    logic        clk = 1'b0;
    logic        rst, clr, stop2b, cts_en, cts_n, wr;
    logic [23:0] ckdiv;
    logic [3:0]  dbits;
    logic [1:0]  parity;
    logic [8:0]  wdata;
    logic        full, empty, ovf, txbusy, done, txd;
    logic [5:0]  level;

    int errors = 0;
    int checks = 0;

    uart_txq #(.DEPTH(32), .WADDR(5), .DIV_W(24)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ckdiv(ckdiv), .dbits(dbits),
        .parity(parity), .stop2b(stop2b), .cts_en(cts_en), .cts_n(cts_n),
        .wr(wr), .wdata(wdata), .full(full), .empty(empty), .level(level),
        .ovf(ovf), .txbusy(txbusy), .done(done), .txd(txd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after the edge where the start bit begins; bits[0] is the start bit.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nb, input int per);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < per; c++) begin
                check({tag, "_txd"}, 32'(txd), 32'(bits[b]));
                check({tag, "_busy"}, 32'(txbusy), 1);
                check({tag, "_done"}, 32'(done), 32'(b == nb - 1 && c == per - 1));
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr = 1'b0; wdata = '0;
        ckdiv = 24'd3; dbits = 4'd8; parity = 2'b00; stop2b = 1'b0;
        cts_en = 1'b0; cts_n = 1'b1;
        #2;
        check("rst_txd", 32'(txd), 1);
        check("rst_busy", 32'(txbusy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_level", 32'(level), 0);
        check("rst_ovf", 32'(ovf), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 8N1, ckdiv=3, 0xA5
        wr = 1'b1; wdata = 9'h0A5;
        tick();
        wr = 1'b0;
        check("lat_empty", 32'(empty), 0);
        check("lat_level", 32'(level), 1);
        check("lat_txd", 32'(txd), 1);
        check("lat_busy", 32'(txbusy), 0);
        tick();
        check("lat_pop_level", 32'(level), 0);
        check("lat_pop_empty", 32'(empty), 1);
        check_frame("b8n1", 16'h034A, 10, 4);
        check("b8n1_end_busy", 32'(txbusy), 0);
        check("b8n1_end_txd", 32'(txd), 1);
        check("b8n1_end_done", 32'(done), 0);

        // 7 bits even parity 0x03, then 9 bits odd parity 0x1FF
        ckdiv = 24'd1; dbits = 4'd7; parity = 2'b10;
        wr = 1'b1; wdata = 9'h003;
        tick();
        wr = 1'b0;
        tick();
        check_frame("p7e", 16'h0206, 10, 2);
        dbits = 4'd9; parity = 2'b01;
        wr = 1'b1; wdata = 9'h1FF;
        tick();
        wr = 1'b0;
        tick();
        check_frame("p9o", 16'h0BFE, 12, 2);

        // dbits=12 acts as 9; second byte written on the pop edge, sent with dbits=2 (acts as 5)
        parity = 2'b00; dbits = 4'd12;
        wr = 1'b1; wdata = 9'h155;
        tick();
        wdata = 9'h1F3;
        tick();
        wr = 1'b0; dbits = 4'd2;
        check("popwr_level", 32'(level), 1);
        check_frame("d12", 16'h06AA, 11, 2);
        check_frame("d2", 16'h0066, 7, 2);
        check("d2_end_busy", 32'(txbusy), 0);

        // Back-to-back, ckdiv=0, two stop bits, queued behind CTS
        dbits = 4'd8; ckdiv = 24'd0; stop2b = 1'b1; cts_en = 1'b1;
        wr = 1'b1; wdata = 9'h000; tick();
        wdata = 9'h0FF; tick();
        wdata = 9'h05A; tick();
        wr = 1'b0;
        check("b2b_level3", 32'(level), 3);
        check("b2b_hold_txd", 32'(txd), 1);
        cts_n = 1'b0;
        tick(); tick();
        check("b2b_cts_txd2", 32'(txd), 1);
        tick();
        check("b2b_level2", 32'(level), 2);
        check_frame("b2b_f1", 16'h0600, 11, 1);
        check("b2b_level1", 32'(level), 1);
        check_frame("b2b_f2", 16'h07FE, 11, 1);
        check("b2b_level0", 32'(level), 0);
        check("b2b_empty", 32'(empty), 1);
        check_frame("b2b_f3", 16'h06B4, 11, 1);
        check("b2b_end_busy", 32'(txbusy), 0);
        check("b2b_end_txd", 32'(txd), 1);
        cts_n = 1'b1; stop2b = 1'b0; ckdiv = 24'd1;
        tick(); tick(); tick();

        // Flow control: held, released, re-asserted mid-frame
        wr = 1'b1; wdata = 9'h00F; tick();
        wdata = 9'h0F0; tick();
        wr = 1'b0;
        tick(); tick(); tick(); tick();
        check("fc_hold_txd", 32'(txd), 1);
        check("fc_hold_level", 32'(level), 2);
        check("fc_hold_busy", 32'(txbusy), 0);
        cts_n = 1'b0;
        tick(); tick();
        check("fc_rel_txd2", 32'(txd), 1);
        tick();
        check("fc_rel_level", 32'(level), 1);
        cts_n = 1'b1;
        check_frame("fc1", 16'h021E, 10, 2);
        check("fc1_end_busy", 32'(txbusy), 0);
        check("fc1_end_level", 32'(level), 1);
        tick(); tick(); tick(); tick();
        check("fc_held_txd", 32'(txd), 1);
        check("fc_held_level", 32'(level), 1);
        cts_en = 1'b0;
        tick();
        check("fc2_level", 32'(level), 0);
        check_frame("fc2", 16'h03E0, 10, 2);

        // Overflow while held, then clear
        cts_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wr = 1'b1; wdata = 9'(i); tick();
        end
        wr = 1'b0;
        check("ovf_full", 32'(full), 1);
        check("ovf_level32", 32'(level), 32);
        check("ovf_pre", 32'(ovf), 0);
        wr = 1'b1; wdata = 9'h1AB; tick();
        wr = 1'b0;
        check("ovf_set", 32'(ovf), 1);
        check("ovf_level_drop", 32'(level), 32);
        check("ovf_txd", 32'(txd), 1);
        clr = 1'b1; tick();
        clr = 1'b0;
        check("clr_level", 32'(level), 0);
        check("clr_ovf", 32'(ovf), 0);
        check("clr_txd", 32'(txd), 1);
        check("clr_empty", 32'(empty), 1);
        check("clr_full", 32'(full), 0);

        // Overflow on a write coinciding with a pop
        for (int i = 0; i < 32; i++) begin
            wr = 1'b1; wdata = 9'(i); tick();
        end
        wr = 1'b1; wdata = 9'h1AB; cts_en = 1'b0; tick();
        wr = 1'b0;
        check("ovfpop_ovf", 32'(ovf), 1);
        check("ovfpop_level", 32'(level), 31);
        check("ovfpop_full", 32'(full), 0);
        check("ovfpop_txd", 32'(txd), 0);
        clr = 1'b1; tick();
        clr = 1'b0;
        check("clr2_txd", 32'(txd), 1);
        check("clr2_busy", 32'(txbusy), 0);
        check("clr2_level", 32'(level), 0);
        check("clr2_ovf", 32'(ovf), 0);

        // Asynchronous reset during DATA
        ckdiv = 24'd3; dbits = 4'd8; parity = 2'b01;
        wr = 1'b1; wdata = 9'h081; tick();
        wdata = 9'h07E; tick();
        wr = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        check("rmf_busy_pre", 32'(txbusy), 1);
        #2 rst = 1'b1;
        #1;
        check("rmf_txd", 32'(txd), 1);
        check("rmf_busy", 32'(txbusy), 0);
        check("rmf_level", 32'(level), 0);
        check("rmf_empty", 32'(empty), 1);
        check("rmf_done", 32'(done), 0);
        #1 rst = 1'b0;
        tick(); tick();
        check("rmf_after_txd", 32'(txd), 1);
        check("rmf_after_busy", 32'(txbusy), 0);

        // Clear during the parity bit, with a write in the same cycle
        ckdiv = 24'd1; dbits = 4'd5; parity = 2'b01;
        wr = 1'b1; wdata = 9'h000; tick();
        wdata = 9'h001; tick();
        wr = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("cpar_bit", 32'(txd), 1);
        check("cpar_level", 32'(level), 1);
        clr = 1'b1; wr = 1'b1; wdata = 9'h055;
        tick();
        clr = 1'b0; wr = 1'b0;
        check("cpar_txd", 32'(txd), 1);
        check("cpar_busy", 32'(txbusy), 0);
        check("cpar_level0", 32'(level), 0);
        check("cpar_empty", 32'(empty), 1);
        check("cpar_ovf", 32'(ovf), 0);
        check("cpar_done", 32'(done), 0);
        tick();
        check("cpar_wr_ignored", 32'(empty), 1);
        check("cpar_idle_txd", 32'(txd), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_txq.md
Name: uart_txq

Overview:
Parametrised next-generation UART transmit channel with its own FIFO. It is a drop-in for the transmit half of the UART peripheral and adds runtime data length (5-9 bits), parity generation, CTS hardware flow control and an overflow flag. The register block drives it, and it produces the serial txd line.

Parameters:
DEPTH, 32, FIFO entries; power of two
WADDR, 5, log2(DEPTH)
DIV_W, 24, width of the baud divider

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear: flush FIFO, abort frame, clear ovf
ckdiv  input  DIV_W  bit period minus 1, in clk cycles
dbits  input  4  data bits per frame, 5..9
parity  input  2  00 none, 01 odd, 10 even, 11 mark (always 1)
stop2b  input  1  1 = two stop bits, 0 = one
cts_en  input  1  enables flow control
cts_n  input  1  asynchronous clear-to-send, active-low
wr  input  1  FIFO write strobe
wdata  input  9  frame data; bits above dbits ignored
full  output  1  FIFO full
empty  output  1  FIFO empty
level  output  WADDR+1  FIFO occupancy, 0..DEPTH
ovf  output  1  sticky: a write was dropped while full
txbusy  output  1  frame in progress
done  output  1  one-cycle pulse at the end of each frame
txd  output  1  serial output, idle high

Behaviour:
- Reset (rst high, asynchronous) values: txd=1, txbusy=0, done=0, full=0, empty=1, level=0, ovf=0, FSM=IDLE, CTS synchroniser=1.
- FIFO write: wr with full=0 stores wdata at the tail. wr with full=1 drops the data and sets ovf; this holds even if a pop occurs in the same cycle.
- FIFO level: a simultaneous accepted write and pop leaves level unchanged. full = (level==DEPTH). empty = (level==0). Pointers wrap modulo DEPTH.
- clr: takes priority over wr and pop in the same cycle. It sets level=0, FSM=IDLE, txd=1, txbusy=0, ovf=0.
- CTS: cts_n passes through a 2-flop synchroniser giving cts_s. Frame start is allowed when cts_en=0 or cts_s=0.
- CTS timing: CTS is checked only at frame start. Deasserting CTS mid-frame never truncates a frame.
- Bit period: every bit lasts exactly ckdiv+1 clk cycles. ckdiv=0 gives 1 cycle per bit.
- Frame latch: ckdiv, dbits, parity and stop2b are latched at frame start. Changes during a frame take effect on the next frame.
- dbits clamp: values below 5 act as 5; values above 9 act as 9.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: if empty=0 and start is allowed, pop the head, latch the data and config, and go to START. txd=0 and txbusy=1 from the next edge.
- START: txd=0 for one bit period, then go to DATA.
- DATA: send data bits LSB first, dbits bits total. Then go to PAR if parity!=00, else STOP.
- PAR: send one parity bit. Odd: XOR of the data bits, inverted. Even: XOR of the data bits. Mark: 1. Parity covers only the transmitted data bits. Then go to STOP.
- STOP: txd=1 for one or two bit periods. On the final cycle of the last stop bit, pulse done=1. Then:
  - if empty=0 and start is allowed: pop and enter START directly, so back-to-back frames have no idle gap;
  - otherwise go to IDLE and set txbusy=0.
- Latency: wr sampled at edge N into an empty FIFO with CTS allowed leaves empty=0 after edge N. The pop happens at edge N+1, and txd falls after edge N+1.
- Frame length: 1 + dbits + (parity?1:0) + (stop2b?2:1) bit periods.
- Pop and write to the same entry: the pop takes the FIFO head, and the write goes to the tail.

Test Plan:
- Basic 8N1: ckdiv=3, dbits=8, parity=00, write 0xA5 → txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clk. done pulses once at cycle 40 after the start edge. txbusy high for 40 cycles.
- Length and parity: dbits=7 even parity with data 0x03, then dbits=9 odd parity with 0x1FF → parity bit 0, then parity bit 0. Out-of-range dbits=12 behaves as 9 and dbits=2 behaves as 5.
- Back-to-back: write 3 bytes, ckdiv=0, 2 stop bits → three frames with no idle cycle between them. level steps 3→2→1→0 at each START. empty=1 after the third pop.
- Overflow: with cts_en=1 and cts_n=1, write 33 bytes → full=1 after the 32nd write, level=32, ovf=1, and the 33rd byte is dropped. clr → level=0, ovf=0, txd=1.
- Flow control: cts_en=1 and cts_n=1 with 2 bytes queued → txd stays high. Drop cts_n → first start bit within 3 clk. Raise cts_n mid-frame → current frame completes and the second frame is held.
- Reset and clear mid-frame: assert rst during DATA → txd=1, txbusy=0, level=0 immediately. Repeat using clr during PAR → same result at the next edge, and a wr in that same cycle is ignored.
